// File: rtl/mdu_ex.sv
// RV32M execute-stage multiply/divide unit.
// Single-cycle multiply and divide special cases; 32-step restoring divider otherwise.
module mdu_ex (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_stall,
  input  logic        DM_stall,
  input  logic        flush,
  input  logic        E_is_mtype,
  input  logic [3:0]  E_func,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        md_stall,
  output logic [31:0] md_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        sel_q, sel_d;

  logic [2:0]  f3;
  logic        is_div;
  logic        is_rem;
  logic        div_sgn;
  logic        b_zero;
  logic        ovf;
  logic        special;
  logic        normal_div;
  logic        start;

  logic        mul_a_sgn;
  logic        mul_b_sgn;
  logic [32:0] a_ext;
  logic [32:0] b_ext;
  logic signed [65:0] prod;
  logic [31:0] mul_res;
  logic [31:0] sp_res;
  logic [31:0] idle_res;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  logic        unused_ok;

  assign f3         = E_func[2:0];
  assign is_div     = f3[2];
  assign is_rem     = f3[1];
  assign div_sgn    = ~f3[0];
  assign b_zero     = (op_b == 32'd0);
  assign ovf        = div_sgn & (op_a == 32'h8000_0000)
                    & (op_b == 32'hFFFF_FFFF);
  assign special    = is_div & (b_zero | ovf);
  assign normal_div = is_div & ~special;
  assign start      = E_is_mtype & ~flush & ~IM_stall & ~DM_stall;

  assign mul_a_sgn = (f3 == 3'b001) | (f3 == 3'b010);
  assign mul_b_sgn = (f3 == 3'b001);
  assign a_ext     = {mul_a_sgn & op_a[31], op_a};
  assign b_ext     = {mul_b_sgn & op_b[31], op_b};
  assign prod      = $signed(a_ext) * $signed(b_ext);
  assign mul_res   = (f3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

  always_comb begin
    sp_res = '0;
    if (b_zero) begin
      sp_res = is_rem ? op_a : 32'hFFFF_FFFF;
    end else begin
      sp_res = is_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  always_comb begin
    idle_res = '0;
    unique case (1'b1)
      ~is_div: idle_res = mul_res;
      special: idle_res = sp_res;
      default: idle_res = '0;
    endcase
  end

  assign a_neg = div_sgn & op_a[31];
  assign b_neg = div_sgn & op_b[31];
  assign a_abs = a_neg ? (32'd0 - op_a) : op_a;
  assign b_abs = b_neg ? (32'd0 - op_b) : op_b;

  // One restoring step: the dividend shifts out of quo_q as quotient bits shift in.
  assign rem_sh   = {rem_q[31:0], quo_q[31]};
  assign diff     = rem_sh - {1'b0, dvs_q};
  assign step_rem = diff[32] ? rem_sh : diff;
  assign step_quo = {quo_q[30:0], ~diff[32]};
  assign q_fix    = negq_q ? (32'd0 - step_quo) : step_quo;
  assign r_fix    = negr_q ? (32'd0 - step_rem[31:0]) : step_rem[31:0];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (start & normal_div) begin
          rem_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          cnt_d   = '0;
          negq_d  = ~is_rem & (a_neg ^ b_neg);
          negr_d  = is_rem & a_neg;
          sel_d   = is_rem;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          rem_d   = '0;
          quo_d   = '0;
          dvs_d   = '0;
          res_d   = '0;
          cnt_d   = '0;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          sel_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = sel_q ? r_fix : q_fix;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush) begin
          rem_d   = '0;
          quo_d   = '0;
          dvs_d   = '0;
          res_d   = '0;
          cnt_d   = '0;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          sel_d   = 1'b0;
          state_d = S_IDLE;
        end else if (!(IM_stall | DM_stall)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      sel_q   <= sel_d;
    end
  end

  // Gated by rst so the stall drops the instant reset is applied.
  assign md_stall = ~rst & (((state_q == S_IDLE) & start & normal_div)
                  | (state_q == S_BUSY));

  always_comb begin
    md_result = '0;
    if (E_is_mtype) begin
      unique case (state_q)
        S_IDLE:  md_result = idle_res;
        S_DONE:  md_result = res_q;
        default: md_result = '0;
      endcase
    end
  end

  assign unused_ok = ^{E_func[3], prod[65:64], rem_q[32]};

endmodule

// File: tb/tb_mdu_ex.sv
// Directed testbench for mdu_ex.
// Each task drives one scenario and checks results against hand-computed values.
module tb_mdu_ex;

  logic        clk;
  logic        rst;
  logic        IM_stall;
  logic        DM_stall;
  logic        flush;
  logic        E_is_mtype;
  logic [3:0]  E_func;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        md_stall;
  logic [31:0] md_result;

  int checks;
  int errors;

  localparam logic [3:0] F_MUL    = 4'd0;
  localparam logic [3:0] F_MULH   = 4'd1;
  localparam logic [3:0] F_MULHSU = 4'd2;
  localparam logic [3:0] F_MULHU  = 4'd3;
  localparam logic [3:0] F_DIV    = 4'd4;
  localparam logic [3:0] F_DIVU   = 4'd5;
  localparam logic [3:0] F_REM    = 4'd6;
  localparam logic [3:0] F_REMU   = 4'd7;

  mdu_ex dut (
    .clk        (clk),
    .rst        (rst),
    .IM_stall   (IM_stall),
    .DM_stall   (DM_stall),
    .flush      (flush),
    .E_is_mtype (E_is_mtype),
    .E_func     (E_func),
    .op_a       (op_a),
    .op_b       (op_b),
    .md_stall   (md_stall),
    .md_result  (md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a divide from IDLE and counts stall cycles (bounded).
  task automatic do_div(input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int cyc,
                        output logic [31:0] res);
    E_is_mtype = 1'b1;
    E_func     = f;
    op_a       = a;
    op_b       = b;
    #1;
    cyc = 0;
    while (md_stall && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    res = md_result;
  endtask

  task automatic go_idle();
    E_is_mtype = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    IM_stall   = 1'b0;
    DM_stall   = 1'b0;
    flush      = 1'b0;
    E_is_mtype = 1'b0;
    E_func     = '0;
    op_a       = '0;
    op_b       = '0;
    #3;
    checks++;
    if (md_stall !== 1'b0 || md_result !== 32'd0) begin
      errors++;
      $display("FAIL reset: stall=%b result=%h want 0/0",
               md_stall, md_result);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    logic [3:0]  fv [5] = '{4'b1000, F_MULHU, F_MULHSU, F_MULH, F_MUL};
    logic [31:0] av [5] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h00010000};
    logic [31:0] bv [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h00010000};
    logic [31:0] ev [5] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF,
                            32'h00000000, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      E_is_mtype = 1'b1;
      E_func     = fv[i];
      op_a       = av[i];
      op_b       = bv[i];
      #1;
      checks++;
      if (md_result !== ev[i] || md_stall !== 1'b0) begin
        errors++;
        $display("FAIL mul[%0d]: result=%h stall=%b want %h/0",
                 i, md_result, md_stall, ev[i]);
      end
    end
    E_func = F_MULHU;
    op_a   = 32'h00020000;
    op_b   = 32'h00030000;
    #1;
    checks++;
    if (md_result !== 32'h00000006) begin
      errors++;
      $display("FAIL mulhu_mid: result=%h want 00000006", md_result);
    end
    E_is_mtype = 1'b0;
    #1;
    checks++;
    if (md_result !== 32'd0 || md_stall !== 1'b0) begin
      errors++;
      $display("FAIL non_mtype: result=%h stall=%b want 0/0",
               md_result, md_stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div();
    logic [3:0]  fv [3] = '{F_DIV, F_REM, F_DIVU};
    logic [31:0] av [3] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'hFFFFFFEC};
    logic [31:0] ev [3] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'h5555554E};
    int          cyc;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      do_div(fv[i], av[i], 32'd3, cyc, res);
      checks++;
      if (cyc != 33) begin
        errors++;
        $display("FAIL div_lat[%0d]: stall cycles=%0d want 33", i, cyc);
      end
      checks++;
      if (res !== ev[i]) begin
        errors++;
        $display("FAIL div_res[%0d]: result=%h want %h", i, res, ev[i]);
      end
      go_idle();
      checks++;
      if (md_stall !== 1'b0) begin
        errors++;
        $display("FAIL div_idle[%0d]: stall=%b want 0", i, md_stall);
      end
    end
  endtask

  task automatic test_special();
    logic [3:0]  fv [3] = '{F_DIVU, F_REM, F_DIV};
    logic [31:0] av [3] = '{32'd5, 32'd5, 32'h80000000};
    logic [31:0] bv [3] = '{32'd0, 32'd0, 32'hFFFFFFFF};
    logic [31:0] ev [3] = '{32'hFFFFFFFF, 32'd5, 32'h80000000};
    for (int i = 0; i < 3; i++) begin
      E_is_mtype = 1'b1;
      E_func     = fv[i];
      op_a       = av[i];
      op_b       = bv[i];
      #1;
      checks++;
      if (md_stall !== 1'b0 || md_result !== ev[i]) begin
        errors++;
        $display("FAIL special[%0d]: stall=%b result=%h want 0/%h",
                 i, md_stall, md_result, ev[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (md_stall !== 1'b0 || md_result !== ev[i]) begin
        errors++;
        $display("FAIL special_hold[%0d]: stall=%b result=%h want 0/%h",
                 i, md_stall, md_result, ev[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_flush();
    int          cyc;
    logic [31:0] res;
    E_is_mtype = 1'b1;
    E_func     = F_DIV;
    op_a       = 32'd1000;
    op_b       = 32'd3;
    #1;
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (md_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: stall=%b want 1", md_stall);
    end
    flush      = 1'b1;
    E_is_mtype = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: stall=%b want 0", md_stall);
    end
    do_div(F_DIVU, 32'd100, 32'd7, cyc, res);
    checks++;
    if (cyc != 33 || res !== 32'd14) begin
      errors++;
      $display("FAIL flush_next: cycles=%0d result=%h want 33/0000000e",
               cyc, res);
    end
    go_idle();
  endtask

  task automatic test_dm_stall();
    int          cyc;
    logic [31:0] res;
    do_div(F_DIVU, 32'd100, 32'd7, cyc, res);
    checks++;
    if (cyc != 33 || res !== 32'd14) begin
      errors++;
      $display("FAIL dms_div: cycles=%0d result=%h want 33/0000000e",
               cyc, res);
    end
    DM_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (md_result !== 32'd14 || md_stall !== 1'b0) begin
        errors++;
        $display("FAIL dms_hold[%0d]: result=%h stall=%b want e/0",
                 i, md_result, md_stall);
      end
      @(posedge clk);
      #1;
    end
    DM_stall = 1'b0;
    #1;
    checks++;
    if (md_result !== 32'd14 || md_stall !== 1'b0) begin
      errors++;
      $display("FAIL dms_release: result=%h stall=%b want e/0",
               md_result, md_stall);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [31:0] res;
    do_div(F_DIV, 32'hFFFFFFEC, 32'd3, cyc, res);
    checks++;
    if (cyc != 33 || res !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d result=%h want 33/fffffffa",
               cyc, res);
    end
    E_func = F_REMU;
    op_a   = 32'd100;
    op_b   = 32'd7;
    #1;
    checks++;
    if (md_stall !== 1'b0 || md_result !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL b2b_done: stall=%b result=%h want 0/fffffffa",
               md_stall, md_result);
    end
    @(posedge clk);
    #1;
    do_div(F_REMU, 32'd100, 32'd7, cyc, res);
    checks++;
    if (cyc != 33 || res !== 32'd2) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d result=%h want 33/00000002",
               cyc, res);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int          cyc;
    logic [31:0] res;
    E_is_mtype = 1'b1;
    E_func     = F_DIVU;
    op_a       = 32'd100;
    op_b       = 32'd7;
    #1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (md_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy: stall=%b want 1", md_stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (md_stall !== 1'b0 || md_result !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: stall=%b result=%h want 0/0",
               md_stall, md_result);
    end
    E_is_mtype = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0 || md_result !== 32'd0) begin
      errors++;
      $display("FAIL rst_release: stall=%b result=%h want 0/0",
               md_stall, md_result);
    end
    do_div(F_DIVU, 32'd100, 32'd7, cyc, res);
    checks++;
    if (cyc != 33 || res !== 32'd14) begin
      errors++;
      $display("FAIL rst_after: cycles=%0d result=%h want 33/0000000e",
               cyc, res);
    end
    go_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_dm_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
